// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 geometry, derived totals
// and sync windows. Also used by the renderer.
package vga_timing_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int GEN_DIV_DEF   = 8;

    localparam int H_TOTAL_DEF  = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF  = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Inclusive sync windows for the default geometry (656..751, 490..491).
    localparam int HS_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int VS_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    localparam int POS_W = 10;
    typedef logic [POS_W-1:0] pos_t;

    // Increment a raster coordinate, wrapping to 0 after 'last'.
    function automatic pos_t wrap_inc(input pos_t p, input pos_t last);
        return (p == last) ? '0 : p + pos_t'(1);
    endfunction

endpackage

// File: rtl/vga_timing_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with an optional
// rising-edge strobe on the synchronized side.
module sync_edge #(
    parameter bit RISE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [1:0] sync_q;

    // Metastability chain; sync_q[1] is safe to use in the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], d};
    end

    assign q = sync_q[1];

    generate
        if (RISE_EN) begin : g_rise
            logic q_d;

            // Delayed copy of the synchronized level for edge detection.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q_d <= 1'b0;
                else        q_d <= sync_q[1];
            end

            assign rise = sync_q[1] & ~q_d;
        end else begin : g_no_rise
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator with a generation-tick scheduler for
// the Life board. Every output is registered from the next counter values
// so decodes line up with hpos/vpos in the same cycle.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit SYNC_POL  = 1'b0,
    parameter int GEN_DIV   = GEN_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic       gen_tick,
    output logic [7:0] frame_count
);

    localparam int   H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam pos_t H_LAST   = pos_t'(H_TOTAL - 1);
    localparam pos_t V_LAST   = pos_t'(V_TOTAL - 1);
    localparam pos_t H_DISP   = pos_t'(H_DISPLAY);
    localparam pos_t V_DISP   = pos_t'(V_DISPLAY);
    localparam pos_t HS_START = pos_t'(H_DISPLAY + H_FRONT);
    localparam pos_t HS_END   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam pos_t VS_START = pos_t'(V_DISPLAY + V_FRONT);
    localparam pos_t VS_END   = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [7:0] DIV_LAST = 8'(GEN_DIV - 1);

    logic run_s;
    logic run_rise_unused;
    logic step_q_unused;
    logic step_pulse;

    sync_edge #(.RISE_EN(1'b0)) u_run_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (run),
        .q     (run_s),
        .rise  (run_rise_unused)
    );

    sync_edge #(.RISE_EN(1'b1)) u_step_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (step),
        .q     (step_q_unused),
        .rise  (step_pulse)
    );

    pos_t       h_nxt, v_nxt;
    logic       vb_nxt;
    logic [7:0] div_cnt, div_nxt;
    logic       step_pending, pend_nxt, pend_clr;
    logic       tick_nxt;

    // Next raster position; vblank start is judged on it so gen_tick lands
    // in the same cycle the counters read (0, V_DISPLAY).
    always_comb begin
        h_nxt  = wrap_inc(hpos, H_LAST);
        v_nxt  = (hpos == H_LAST) ? wrap_inc(vpos, V_LAST) : vpos;
        vb_nxt = (h_nxt == '0) && (v_nxt == V_DISP);
    end

    // Generation scheduler: divided ticks while running, one tick per
    // pending step while stopped. A new step pulse wins over a clear.
    always_comb begin
        tick_nxt = 1'b0;
        pend_clr = 1'b0;
        div_nxt  = run_s ? div_cnt : '0;
        if (vb_nxt) begin
            if (run_s) begin
                pend_clr = 1'b1;
                if (div_cnt == DIV_LAST) begin
                    tick_nxt = 1'b1;
                    div_nxt  = '0;
                end else begin
                    div_nxt  = div_cnt + 8'd1;
                end
            end else if (step_pending) begin
                tick_nxt = 1'b1;
                pend_clr = 1'b1;
            end
        end
        pend_nxt = step_pulse | (step_pending & ~pend_clr);
    end

    // Counters and registered decodes of the next position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos         <= H_LAST;
            vpos         <= V_LAST;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            display_on   <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            gen_tick     <= 1'b0;
            frame_count  <= '0;
            div_cnt      <= '0;
            step_pending <= 1'b0;
        end else begin
            hpos         <= h_nxt;
            vpos         <= v_nxt;
            hsync        <= (h_nxt >= HS_START && h_nxt <= HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync        <= (v_nxt >= VS_START && v_nxt <= VS_END) ? SYNC_POL : ~SYNC_POL;
            display_on   <= (h_nxt < H_DISP) && (v_nxt < V_DISP);
            line_start   <= (h_nxt == '0);
            frame_start  <= (h_nxt == '0) && (v_nxt == '0);
            gen_tick     <= tick_nxt;
            frame_count  <= frame_count + 8'(frame_start);
            div_cnt      <= div_nxt;
            step_pending <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing on a shrunken raster (15x10 clocks per frame) so
// multi-frame scheduler behaviour fits in a short run.
module tb_vga_timing;

    localparam int FRAME   = 150;   // 15 clocks/line * 10 lines
    localparam int VB_LINE = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [9:0] hpos, vpos;
    logic       hsync, vsync, display_on, line_start, frame_start, gen_tick;
    logic [7:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b0), .GEN_DIV(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .step        (step),
        .hpos        (hpos),
        .vpos        (vpos),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .gen_tick    (gen_tick),
        .frame_count (frame_count)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
        logic       gt;
    } obs_t;

    typedef struct {
        int   cyc;   // rising edges since reset release
        obs_t exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int cyc, input int h, input int v, input int hs,
                                input int vs, input int de, input int ls, input int fs,
                                input int fc, input int gt);
        vec_t r;
        r.cyc    = cyc;
        r.exp.h  = 10'(h);
        r.exp.v  = 10'(v);
        r.exp.hs = 1'(hs);
        r.exp.vs = 1'(vs);
        r.exp.de = 1'(de);
        r.exp.ls = 1'(ls);
        r.exp.fs = 1'(fs);
        r.exp.fc = 8'(fc);
        r.exp.gt = 1'(gt);
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.h  = hpos;        o.v  = vpos;
        o.hs = hsync;       o.vs = vsync;
        o.de = display_on;  o.ls = line_start;
        o.fs = frame_start; o.fc = frame_count;
        o.gt = gen_tick;
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_obs(input string name, input obs_t a, input obs_t e);
        n_checks++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d fc=%0d gt=%0d, expected h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d fc=%0d gt=%0d",
                     name, a.h, a.v, a.hs, a.vs, a.de, a.ls, a.fs, a.fc, a.gt,
                     e.h, e.v, e.hs, e.vs, e.de, e.ls, e.fs, e.fc, e.gt);
        end
    endtask

    // Hold reset for two clocks, release on a falling edge.
    task automatic do_reset(input logic r);
        rst_n = 1'b0;
        run   = r;
        step  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance to the next sample at position (h,v), bounded by two frames.
    task automatic wait_pos(input int h, input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(int'(hpos) == h && int'(vpos) == v) && n < 2 * FRAME);
        if (!(int'(hpos) == h && int'(vpos) == v)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_pos(%0d,%0d): not reached in %0d clocks", h, v, n);
        end
    endtask

    initial begin
        int k;
        int hs_low, hs_first, hs_last, vs_low, vs_first, vs_last;
        int de_all, de_line0, ls_cnt, ls_bad, ls_a, ls_b, fs_cnt;
        int ticks, last_tick;

        // t = edge-1 after release: hpos = t%15, vpos = (t/15)%10
        //               cyc   h  v hs vs de ls fs fc gt
        vecs.push_back(mk(  0, 14, 9, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(  1,  0, 0, 1, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(  2,  1, 0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(  8,  7, 0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(  9,  8, 0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 11, 10, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 13, 12, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 14, 13, 0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 16,  0, 1, 1, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk( 91,  0, 6, 1, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(106,  0, 7, 1, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(135, 14, 8, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(136,  0, 9, 1, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(151,  0, 0, 1, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(152,  1, 0, 1, 1, 1, 0, 0, 2, 0));

        // Table-driven raster checks from reset release.
        do_reset(1'b0);
        k = 0;
        foreach (vecs[i]) begin
            while (k < vecs[i].cyc) begin
                @(negedge clk);
                k++;
            end
            check_obs($sformatf("vec_cyc%0d", vecs[i].cyc), sample(), vecs[i].exp);
        end

        // One full frame of sync/enable measurements.
        do_reset(1'b0);
        wait_pos(0, 0);
        check("fs_first_edge", int'(frame_start), 1);
        hs_low = 0; hs_first = -1; hs_last = -1;
        vs_low = 0; vs_first = -1; vs_last = -1;
        de_all = 0; de_line0 = 0; ls_cnt = 0; ls_bad = 0; fs_cnt = 0;
        ls_a = -1; ls_b = -1;
        for (int c = 0; c < FRAME; c++) begin
            if (!hsync) begin
                hs_low++;
                if (vpos == 10'd0) begin
                    if (hs_first < 0) hs_first = int'(hpos);
                    hs_last = int'(hpos);
                end
            end
            if (!vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(vpos);
                vs_last = int'(vpos);
            end
            if (display_on) begin
                de_all++;
                if (vpos == 10'd0) de_line0++;
            end
            if (line_start) begin
                ls_cnt++;
                if (hpos != 10'd0) ls_bad++;
                if (ls_a < 0) ls_a = c;
                else if (ls_b < 0) ls_b = c;
            end
            if (frame_start) fs_cnt++;
            @(negedge clk);
        end
        check("hsync_low_frame", hs_low, 30);
        check("hsync_first_h", hs_first, 10);
        check("hsync_last_h", hs_last, 12);
        check("vsync_low_clocks", vs_low, 30);
        check("vsync_first_line", vs_first, 7);
        check("vsync_last_line", vs_last, 8);
        check("de_line0", de_line0, 8);
        check("de_frame", de_all, 48);
        check("line_start_count", ls_cnt, 10);
        check("line_start_off_h0", ls_bad, 0);
        check("line_period", ls_b - ls_a, 15);
        check("frame_start_count", fs_cnt, 1);
        check("frame_period", int'(frame_start), 1);
        repeat (2 * FRAME) @(negedge clk);
        check("frame_count_3", int'(frame_count), 3);

        // Auto-advance: 20 frames, tick on every 8th vblank start.
        do_reset(1'b1);
        ticks = 0;
        last_tick = -1;
        for (int i = 1; i <= 20 * FRAME; i++) begin
            @(negedge clk);
            if (gen_tick) begin
                ticks++;
                check("run_tick_h", int'(hpos), 0);
                check("run_tick_v", int'(vpos), VB_LINE);
                if (last_tick < 0) check("run_first_tick_edge", i, 1141);
                else               check("run_tick_interval", i - last_tick, 8 * FRAME);
                last_tick = i;
            end
        end
        check("run_tick_count", ticks, 2);

        // Stopped: two step edges in one frame give a single tick.
        do_reset(1'b0);
        wait_pos(0, 0);
        step = 1'b1; repeat (3) @(negedge clk);
        step = 1'b0; repeat (3) @(negedge clk);
        step = 1'b1; repeat (3) @(negedge clk);
        step = 1'b0;
        ticks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (gen_tick) begin
                ticks++;
                check("step_tick_pos", int'(vpos) * 100 + int'(hpos), VB_LINE * 100);
            end
        end
        check("two_steps_one_tick", ticks, 1);
        ticks = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (gen_tick) ticks++;
        end
        check("no_step_no_tick", ticks, 0);

        // Step whose pulse coincides with the vblank-start edge: deferred.
        wait_pos(12, VB_LINE - 1);
        step = 1'b1;
        wait_pos(0, VB_LINE);
        check("late_step_not_this_vb", int'(gen_tick), 0);
        step = 1'b0;
        wait_pos(0, VB_LINE);
        check("late_step_next_vb", int'(gen_tick), 1);

        // One clock earlier the flag is already set and is served at once.
        wait_pos(11, VB_LINE - 1);
        step = 1'b1;
        wait_pos(0, VB_LINE);
        check("early_step_this_vb", int'(gen_tick), 1);
        step = 1'b0;
        wait_pos(0, VB_LINE);
        check("early_step_no_repeat", int'(gen_tick), 0);

        // Reset mid-frame with a step pending discards it.
        do_reset(1'b0);
        wait_pos(0, 1);
        step = 1'b1;
        wait_pos(0, 2);
        step = 1'b0;
        wait_pos(3, 2);
        rst_n = 1'b0;
        #1;
        check_obs("mid_reset_state", sample(), mk(0, 14, 9, 1, 1, 0, 0, 0, 0, 0).exp);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_obs("after_mid_reset", sample(), mk(1, 0, 0, 1, 1, 1, 1, 1, 0, 0).exp);
        @(negedge clk);
        check("after_mid_reset_fc", int'(frame_count), 1);
        wait_pos(0, VB_LINE);
        check("pending_discarded", int'(gen_tick), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
